// File: rtl/wave_gen_dds.sv
// DDS waveform generator: phase accumulator, six waveform shapes, amplitude scaling and
// config updates that take effect only at a phase wrap so the output never glitches mid-period.
module wave_gen_dds #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [DATA_W-1:0]  cfg_amp,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    output logic               wrap
);

    localparam int WW    = DATA_W + 2;
    localparam int PW    = 2 * DATA_W + 2;
    localparam int LUT_N = 1 << LUT_AW;
    localparam int A_INT = (1 << (DATA_W - 1)) - 1;

    localparam logic signed [WW-1:0]     A_W     = WW'(A_INT);
    localparam logic signed [DATA_W-1:0] W_MAX   = DATA_W'(A_INT);
    localparam logic signed [DATA_W-1:0] W_MIN   = -W_MAX;
    localparam logic [DATA_W-1:0]        MID     = DATA_W'(A_INT);
    localparam logic signed [PW-1:0]     MID_P   = PW'(A_INT);
    localparam logic signed [PW-1:0]     OUT_MAX = PW'((1 << DATA_W) - 1);

    localparam logic [2:0] MODE_SQUARE = 3'd0;
    localparam logic [2:0] MODE_TRI    = 3'd1;
    localparam logic [2:0] MODE_SINE   = 3'd2;
    localparam logic [2:0] MODE_FULL   = 3'd3;
    localparam logic [2:0] MODE_HALF   = 3'd4;
    localparam logic [2:0] MODE_SAW    = 3'd5;

    // Quarter-wave entry round(A*sin(pi/2*i/N)), evaluated at elaboration with a
    // Q30 fixed-point Taylor series so no real arithmetic reaches the netlist.
    function automatic int sine_entry(input int i);
        longint half_pi_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        half_pi_q30 = 64'sd1686629713;
        x    = (half_pi_q30 * longint'(i)) / longint'(LUT_N);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x2) >>> 30;
            term = term / longint'((2 * k) * (2 * k + 1));
            if (k % 2 == 1) sum = sum - term;
            else            sum = sum + term;
        end
        return int'((sum * longint'(A_INT) + 64'sd536870912) >>> 30);
    endfunction

    logic [DATA_W-1:0] lut [LUT_N];

    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        localparam int Entry = sine_entry(g);
        assign lut[g] = DATA_W'(Entry);
    end

    // Active and pending configuration
    logic [PHASE_W-1:0] acc_q;
    logic               wrap_q;
    logic [2:0]         mode_q;
    logic [PHASE_W-1:0] ftw_q;
    logic [DATA_W-1:0]  amp_q;
    logic               pend_q;
    logic [2:0]         pmode_q;
    logic [PHASE_W-1:0] pftw_q;
    logic [DATA_W-1:0]  pamp_q;

    // Pipeline stages
    logic signed [DATA_W-1:0] w1_q;
    logic [DATA_W-1:0]        amp1_q;
    logic                     v1_q;
    logic [DATA_W-1:0]        sample_q;
    logic                     valid_q;

    logic [PHASE_W:0]   sum_w;
    logic               carry;
    logic [PHASE_W-1:0] acc_d;
    logic               accept;
    logic               apply;

    // Handshake: a config transfers on an edge where cfg_valid and cfg_ready are both high.
    // cfg_ready is low while a config is pending, so an offer held high simply waits.
    assign sum_w     = {1'b0, acc_q} + {1'b0, ftw_q};
    assign carry     = sum_w[PHASE_W];
    assign acc_d     = sum_w[PHASE_W-1:0];
    assign cfg_ready = ~pend_q;
    assign accept    = cfg_valid & ~pend_q;
    assign apply     = pend_q & (~en | carry);

    logic                     msb;
    logic [DATA_W-1:0]        tri_t;
    logic [DATA_W-1:0]        saw_t;
    logic [LUT_AW-1:0]        sin_idx;
    logic [DATA_W-1:0]        sin_mag;
    logic signed [WW-1:0]     sin_mag_s;
    logic signed [WW-1:0]     tri_s;
    logic signed [WW-1:0]     saw_s;
    logic signed [WW-1:0]     raw_w;
    logic signed [DATA_W-1:0] w_d;

    always_comb begin
        msb       = acc_q[PHASE_W-1];
        tri_t     = acc_q[PHASE_W-2 -: DATA_W];
        saw_t     = acc_q[PHASE_W-1 -: DATA_W];
        sin_idx   = acc_q[PHASE_W-2] ? ~acc_q[PHASE_W-3 -: LUT_AW] : acc_q[PHASE_W-3 -: LUT_AW];
        sin_mag   = lut[sin_idx];
        sin_mag_s = $signed({2'b00, sin_mag});
        tri_s     = $signed({2'b00, tri_t});
        saw_s     = $signed({2'b00, saw_t});
        raw_w     = '0;
        case (mode_q)
            MODE_SQUARE: raw_w = msb ? -A_W : A_W;
            MODE_TRI:    raw_w = msb ? (A_W - tri_s) : (tri_s - A_W);
            MODE_SINE:   raw_w = msb ? -sin_mag_s : sin_mag_s;
            MODE_FULL:   raw_w = sin_mag_s;
            MODE_HALF:   raw_w = msb ? '0 : sin_mag_s;
            MODE_SAW:    raw_w = saw_s - A_W;
            default:     raw_w = '0;
        endcase
        if (raw_w > A_W)       w_d = W_MAX;
        else if (raw_w < -A_W) w_d = W_MIN;
        else                   w_d = raw_w[DATA_W-1:0];
    end

    logic [DATA_W:0]      amp_p1;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [PW-1:0] biased;
    logic [DATA_W-1:0]    sample_d;

    // Scale by (amp+1)/2^DATA_W with floor, recentre on midscale, clamp to the DAC range.
    always_comb begin
        amp_p1  = {1'b0, amp1_q} + (DATA_W + 1)'(1);
        prod    = $signed({{(PW - DATA_W){w1_q[DATA_W-1]}}, w1_q})
                * $signed({{(PW - DATA_W - 1){1'b0}}, amp_p1});
        shifted = prod >>> DATA_W;
        biased  = shifted + MID_P;
        if (biased[PW-1])          sample_d = '0;
        else if (biased > OUT_MAX) sample_d = '1;
        else                       sample_d = biased[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= MODE_SQUARE;
            ftw_q   <= '0;
            amp_q   <= '1;
            pend_q  <= 1'b0;
            pmode_q <= MODE_SQUARE;
            pftw_q  <= '0;
            pamp_q  <= '1;
        end else begin
            if (en) acc_q <= acc_d;
            wrap_q <= en & carry;
            // The sample for the wrapping phase was taken with the old config above.
            if (apply) begin
                mode_q <= pmode_q;
                ftw_q  <= pftw_q;
                amp_q  <= pamp_q;
                pend_q <= 1'b0;
            end else if (accept) begin
                pmode_q <= cfg_mode;
                pftw_q  <= cfg_ftw;
                pamp_q  <= cfg_amp;
                pend_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w1_q     <= '0;
            amp1_q   <= '1;
            v1_q     <= 1'b0;
            sample_q <= MID;
            valid_q  <= 1'b0;
        end else begin
            if (en) begin
                w1_q   <= w_d;
                amp1_q <= amp_q;
            end
            v1_q    <= en;
            if (v1_q) sample_q <= sample_d;
            valid_q <= v1_q;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign wrap         = wrap_q;

endmodule
